// File: rtl/mvm_arbiter.sv
// Round-robin owner of one shared MVM engine: a whole job of IN_WORDS beats in, OUT_WORDS out.
// Data paths are pure combinational forwarding; arbitration costs one IDLE cycle.
module mvm_arbiter #(
    parameter int IN_WORDS  = 12,
    parameter int OUT_WORDS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s0_valid,
    output logic               s0_ready,
    input  logic signed [7:0]  s0_data,
    input  logic               s1_valid,
    output logic               s1_ready,
    input  logic signed [7:0]  s1_data,
    output logic               e_s_valid,
    input  logic               e_s_ready,
    output logic [7:0]         e_data_in,
    input  logic               e_m_valid,
    output logic               e_m_ready,
    input  logic signed [15:0] e_data_out,
    input  logic               e_overflow,
    output logic               m0_valid,
    input  logic               m0_ready,
    output logic signed [15:0] m0_data,
    output logic               m0_overflow,
    output logic               m1_valid,
    input  logic               m1_ready,
    output logic signed [15:0] m1_data,
    output logic               m1_overflow,
    output logic [1:0]         grant,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

    state_t     state;
    logic       owner;
    logic       last_owner;
    logic [3:0] in_cnt;
    logic [1:0] out_cnt;

    logic feed;
    logic drain;
    logic in_fire;
    logic out_fire;
    logic pick;

    assign feed     = (state == FEED);
    assign drain    = (state == DRAIN);
    assign in_fire  = e_s_valid & e_s_ready;
    assign out_fire = e_m_valid & e_m_ready;
    // On a tie the requester that did not own the previous job wins.
    assign pick     = (s0_valid & s1_valid) ? ~last_owner : s1_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            in_cnt     <= '0;
            out_cnt    <= '0;
            grant      <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_valid | s1_valid) begin
                        owner <= pick;
                        grant <= pick ? 2'b10 : 2'b01;
                        state <= FEED;
                    end
                end
                FEED: begin
                    if (in_fire) begin
                        if (in_cnt == 4'(IN_WORDS - 1)) begin
                            in_cnt <= '0;
                            state  <= DRAIN;
                        end else begin
                            in_cnt <= in_cnt + 4'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (out_cnt == 2'(OUT_WORDS - 1)) begin
                            out_cnt    <= '0;
                            last_owner <= owner;
                            grant      <= 2'b00;
                            state      <= IDLE;
                        end else begin
                            out_cnt <= out_cnt + 2'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

    assign e_s_valid = feed & (owner ? s1_valid : s0_valid);
    assign e_data_in = e_s_valid ? (owner ? s1_data : s0_data) : 8'd0;
    assign s0_ready  = feed & ~owner & e_s_ready;
    assign s1_ready  = feed & owner & e_s_ready;

    assign e_m_ready   = drain & (owner ? m1_ready : m0_ready);
    assign m0_valid    = drain & ~owner & e_m_valid;
    assign m1_valid    = drain & owner & e_m_valid;
    assign m0_data     = m0_valid ? e_data_out : 16'sd0;
    assign m1_data     = m1_valid ? e_data_out : 16'sd0;
    assign m0_overflow = m0_valid & e_overflow;
    assign m1_overflow = m1_valid & e_overflow;

endmodule

// File: doc/mvm_arbiter.md
MVM_ARBITER -- requirements
Module: mvm_arbiter

Interface
REQ-001 SHALL have parameter IN_WORDS, default 12, meaning input beats per job (9 matrix + 3 vector).
REQ-002 SHALL have parameter OUT_WORDS, default 3, meaning result beats per job.
REQ-003 SHALL have the following ports; clock clk; reset reset, synchronous, active-high:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- s0_valid / s0_ready  in / out  1 / 1  requester-0 input handshake
- s0_data  in  8  requester-0 input word, signed
- s1_valid / s1_ready / s1_data  in / out / in  1 / 1 / 8  requester-1 input, same as requester 0
- e_s_valid / e_s_ready  out / in  1 / 1  engine input handshake
- e_data_in  out  8  engine input word
- e_m_valid / e_m_ready  in / out  1 / 1  engine output handshake
- e_data_out  in  16  engine result, signed
- e_overflow  in  1  engine overflow flag
- m0_valid / m0_ready  out / in  1 / 1  requester-0 result handshake
- m0_data / m0_overflow  out  16 / 1  requester-0 result and overflow
- m1_valid / m1_ready / m1_data / m1_overflow  out / in / out / out  1 / 1 / 16 / 1  requester-1 result, same as requester 0
- grant  out  2  one-hot current owner, 00 when idle
- busy  out  1  high in FEED or DRAIN

Function
REQ-004 SHALL share one MVM engine between two requesters, one whole job (IN_WORDS in, OUT_WORDS out) at a time.
REQ-005 SHALL implement FSM IDLE -> FEED -> DRAIN -> IDLE.
REQ-006 IDLE: owner selection
- If exactly one sX_valid=1, grant that requester.
- If both are 1, grant the requester other than last_owner (round-robin).
- Registered grant, move to FEED next cycle.
- All readies and valids 0 while in IDLE.
REQ-007 FEED, combinational passthrough for owner g:
- e_s_valid = sg_valid
- sg_ready = e_s_ready
- e_data_in = sg_data
- Non-owner s_ready = 0.
REQ-008 FEED: in_cnt (4 bits) SHALL increment on each e_s_valid & e_s_ready; on the beat where in_cnt = IN_WORDS-1, in_cnt SHALL clear and FSM SHALL move to DRAIN.
REQ-009 DRAIN, combinational passthrough for owner g:
- mg_valid = e_m_valid
- e_m_ready = mg_ready
- mg_data = e_data_out
- mg_overflow = e_overflow
- Non-owner m_valid = 0.
- All s_ready = 0.
REQ-010 DRAIN: out_cnt (2 bits) SHALL increment on each e_m_valid & e_m_ready; on the beat where out_cnt = OUT_WORDS-1, out_cnt SHALL clear, last_owner <= g, and FSM SHALL move to IDLE.
REQ-011 SHALL drive e_data_in = 0 whenever e_s_valid = 0, and mX_data = 0, mX_overflow = 0 whenever mX_valid = 0.
REQ-012 e_m_ready SHALL be 0 outside DRAIN; e_s_valid SHALL be 0 outside FEED.
REQ-013 Backpressure: on either side, a stalled beat (valid & !ready) SHALL NOT advance any counter, with data held by the source.
REQ-014 A non-owner asserting valid during FEED/DRAIN SHALL be ignored until the next IDLE evaluation; its request SHALL then win by round-robin.
REQ-015 SHALL add no latency on data paths (pure combinational forwarding); arbitration costs exactly one cycle in IDLE.
REQ-016 grant SHALL be one-hot and stable for the entire job; busy = (state != IDLE).

Reset
REQ-017 On reset: state = IDLE, in_cnt = 0, out_cnt = 0, last_owner = 1 (requester 0 wins the first tie), grant = 00, busy = 0, all valid/ready outputs = 0, all data outputs = 0.
REQ-018 Reset mid-job SHALL abort immediately to IDLE; the engine SHALL share the same reset, and no partial result SHALL be forwarded afterwards.

Verification
REQ-019 Single requester: s0 sends 12 beats {1,-8,3,9,-5,11,-7,8,-9,1,-22,3} -> m0 receives 186, 152, -210 with overflow 0; m1_valid never 1; grant = 01 throughout.
REQ-020 Simultaneous s0_valid/s1_valid after reset -> s0 job served first, then s1; repeated contention -> strict alternation 0,1,0,1.
REQ-021 s1 job {10,11,12,127,127,127,1,2,3,127,127,127} -> m1 gets 4191, -17149 (overflow 1), 762.
REQ-022 Random valid/ready toggling on s, e, and m sides -> exactly 12 input and 3 output transfers per job, no duplicate or dropped beats, counters frozen on stalls.
REQ-023 Reset asserted after 5 input beats -> next cycle grant = 00, busy = 0, all readies 0; a new full job afterwards completes correctly.
REQ-024 s1_valid held high during s0 DRAIN -> s1_ready = 0 until s0's 3rd result accepted, then one IDLE cycle, then grant = 10.
